// File: rtl/i2c_master_byte_ctrl.sv
// Single-byte I2C master: START, address + R/W, one data byte, STOP.
// SCL is generated in quarter periods of CLK_DIV clocks; SCL and SDA are open-drain.
module i2c_master_byte_ctrl #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output wire        scl,
  inout  wire        sda
);

  localparam int unsigned   CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_RNACK, S_STOP
  } state_t;

  state_t        state, state_n;
  logic [1:0]    q, q_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    tx_sh, tx_n;
  logic [7:0]    rx_sh, rx_n;
  logic          rw_q, rw_n;
  logic [7:0]    wdata_q, wdata_n;
  logic          ack_smp, ack_smp_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          scl_low, scl_low_n;
  logic          sda_low, sda_low_n;
  logic [7:0]    rdata_n;
  logic          busy_n, done_n, ack_err_n;
  logic          tick;
  logic          sda_in;

  assign scl    = scl_low ? 1'b0 : 1'bz;
  assign sda    = sda_low ? 1'b0 : 1'bz;
  assign sda_in = sda;
  assign tick   = busy && (cnt == CNT_MAX);

  // SCL is low in Q0/Q1 of every slot except START, which only pulls it low in Q3.
  function automatic logic scl_low_of(input state_t s, input logic [1:0] qq);
    case (s)
      S_IDLE:  return 1'b0;
      S_START: return qq == 2'd3;
      default: return ~qq[1];
    endcase
  endfunction

  function automatic logic sda_low_of(input state_t s, input logic [1:0] qq, input logic b);
    case (s)
      S_START:      return qq[1];
      S_STOP:       return qq != 2'd3;
      S_ADDR, S_WR: return ~b;
      default:      return 1'b0;
    endcase
  endfunction

  // Next-state logic; line levels are derived from the next state so they are
  // registered together with it and change exactly at quarter boundaries.
  always_comb begin
    state_n   = state;
    q_n       = q;
    bit_n     = bit_cnt;
    tx_n      = tx_sh;
    rx_n      = rx_sh;
    rw_n      = rw_q;
    wdata_n   = wdata_q;
    ack_smp_n = ack_smp;
    ack_err_n = ack_err;
    rdata_n   = rdata;
    busy_n    = busy;
    done_n    = 1'b0;
    cnt_n     = '0;
    if (busy) cnt_n = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;

    if (state == S_IDLE) begin
      if (start) begin
        state_n   = S_START;
        q_n       = '0;
        bit_n     = '0;
        tx_n      = {addr, rw};
        rw_n      = rw;
        wdata_n   = wdata;
        ack_err_n = 1'b0;
        busy_n    = 1'b1;
      end
    end else if (tick) begin
      q_n = q + 2'd1;
      // Q2->Q3 boundary: SCL has been high for a full quarter
      if (q == 2'd2) begin
        ack_smp_n = sda_in;
        if (state == S_RD) rx_n = {rx_sh[6:0], sda_in};
      end
      if (q == 2'd3) begin
        case (state)
          S_START: state_n = S_ADDR;
          S_ADDR: begin
            if (bit_cnt == 3'd7) begin
              state_n = S_AACK;
              bit_n   = '0;
            end else begin
              bit_n = bit_cnt + 3'd1;
              tx_n  = {tx_sh[6:0], 1'b0};
            end
          end
          S_AACK: begin
            if (ack_smp) begin
              ack_err_n = 1'b1;
              state_n   = S_STOP;
            end else if (rw_q) begin
              state_n = S_RD;
            end else begin
              state_n = S_WR;
              tx_n    = wdata_q;
            end
          end
          S_WR: begin
            if (bit_cnt == 3'd7) begin
              state_n = S_WACK;
              bit_n   = '0;
            end else begin
              bit_n = bit_cnt + 3'd1;
              tx_n  = {tx_sh[6:0], 1'b0};
            end
          end
          S_WACK: begin
            if (ack_smp) ack_err_n = 1'b1;
            state_n = S_STOP;
          end
          S_RD: begin
            if (bit_cnt == 3'd7) begin
              state_n = S_RNACK;
              bit_n   = '0;
            end else begin
              bit_n = bit_cnt + 3'd1;
            end
          end
          S_RNACK: begin
            rdata_n = rx_sh;
            state_n = S_STOP;
          end
          S_STOP: begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
          default: state_n = S_IDLE;
        endcase
      end
    end

    scl_low_n = scl_low_of(state_n, q_n);
    sda_low_n = sda_low_of(state_n, q_n, tx_n[7]);
  end

  // State, counters and registered outputs; reset releases both lines at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      q       <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      ack_smp <= 1'b0;
      cnt     <= '0;
      scl_low <= 1'b0;
      sda_low <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      state   <= state_n;
      q       <= q_n;
      bit_cnt <= bit_n;
      tx_sh   <= tx_n;
      rx_sh   <= rx_n;
      rw_q    <= rw_n;
      wdata_q <= wdata_n;
      ack_smp <= ack_smp_n;
      cnt     <= cnt_n;
      scl_low <= scl_low_n;
      sda_low <= sda_low_n;
      rdata   <= rdata_n;
      busy    <= busy_n;
      done    <= done_n;
      ack_err <= ack_err_n;
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Bench for i2c_master_byte_ctrl: behavioural 8-bit IO slave at 7'h27, a bus
// checker on the sampled lines, and a scoreboard of expected transaction results.
`timescale 1ns/1ps
module tb_i2c_master_byte_ctrl;

  localparam int unsigned CLK_DIV  = 4;
  localparam logic [6:0]  SLV_ADDR = 7'h27;
  localparam int unsigned FULL_LEN = 80 * CLK_DIV;
  localparam int unsigned NACK_LEN = 44 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset, start, rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy, done, ack_err;
  wire        scl_line, sda_line;
  logic       s_drive = 1'b0;

  always #5 clk = ~clk;

  pullup (scl_line);
  pullup (sda_line);
  assign sda_line = s_drive ? 1'b0 : 1'bz;

  i2c_master_byte_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .addr    (addr),
    .rw      (rw),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .scl     (scl_line),
    .sda     (sda_line)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        ack;
    logic [7:0]  rd;
    logic [31:0] len;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  exp_rdata = 8'h00;
  logic [7:0]  exp_io    = 8'h00;
  int unsigned done_cnt  = 0;
  int unsigned busy_cycles = 0;
  logic        prev_done = 1'b0;

  // Scoreboard side: every done pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cycles = 0;
      prev_done   = 1'b0;
    end else begin
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
        chk("done_single_pulse", prev_done, 1'b0);
        chk("done_has_expect", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("ack_err", ack_err, e.ack);
          chk("rdata", rdata, e.rd);
          chk("busy_len", busy_cycles, e.len);
        end
        chk("busy_low_at_done", busy, 1'b0);
        busy_cycles = 0;
      end
      prev_done = done;
    end
  end

  // Slave model and bus checker, both working on line samples taken mid-cycle
  typedef enum {SP_IDLE, SP_ADDR, SP_AACK, SP_WDATA, SP_WACK, SP_RDATA, SP_RACK} sp_t;
  sp_t         s_phase   = SP_IDLE;
  int unsigned s_bits    = 0;
  logic [7:0]  s_sh      = 8'h00;
  logic [7:0]  s_tx      = 8'h00;
  logic [7:0]  s_io      = 8'h00;
  logic        s_rd      = 1'b0;
  logic        m_ack     = 1'b0;
  int unsigned n_start   = 0;
  int unsigned n_stop    = 0;
  logic        p_scl     = 1'b1;
  logic        p_sda     = 1'b1;
  logic        c_scl, c_sda;
  logic        in_frame  = 1'b0;
  logic        first_low = 1'b0;
  logic        hi_valid  = 1'b0;
  int unsigned half_cnt  = 0;
  int unsigned half_bad  = 0;

  always @(negedge clk) begin
    c_scl = scl_line;
    c_sda = sda_line;
    if (reset) begin
      s_phase  = SP_IDLE;
      s_drive  = 1'b0;
      in_frame = 1'b0;
      hi_valid = 1'b0;
    end else begin
      if (c_scl && p_scl && (c_sda != p_sda)) begin
        if (!c_sda) begin
          n_start++;
          s_phase   = SP_ADDR;
          s_bits    = 0;
          s_drive   = 1'b0;
          in_frame  = 1'b1;
          first_low = 1'b1;
          hi_valid  = 1'b0;
        end else begin
          n_stop++;
          s_phase  = SP_IDLE;
          s_drive  = 1'b0;
          in_frame = 1'b0;
          hi_valid = 1'b0;
        end
      end
      if (c_scl != p_scl) begin
        if (in_frame) begin
          if (c_scl) begin
            if (half_cnt != (first_low ? 3 * CLK_DIV : 2 * CLK_DIV)) half_bad++;
            first_low = 1'b0;
            hi_valid  = 1'b1;
          end else if (hi_valid && half_cnt != 2 * CLK_DIV) begin
            half_bad++;
          end
        end
        half_cnt = 1;
        if (c_scl) begin
          case (s_phase)
            SP_ADDR, SP_WDATA: if (s_bits < 8) begin
              s_sh = {s_sh[6:0], c_sda};
              s_bits++;
            end
            SP_RDATA: s_bits++;
            SP_RACK: begin
              m_ack   = c_sda;
              s_phase = SP_IDLE;
            end
            default: ;
          endcase
        end else begin
          case (s_phase)
            SP_ADDR: if (s_bits == 8) begin
              if (s_sh[7:1] == SLV_ADDR) begin
                s_rd    = s_sh[0];
                s_drive = 1'b1;
                s_phase = SP_AACK;
              end else begin
                s_phase = SP_IDLE;
              end
            end
            SP_AACK: begin
              s_bits = 0;
              if (s_rd) begin
                s_tx    = s_io;
                s_drive = ~s_tx[7];
                s_phase = SP_RDATA;
              end else begin
                s_drive = 1'b0;
                s_phase = SP_WDATA;
              end
            end
            SP_WDATA: if (s_bits == 8) begin
              s_io    = s_sh;
              s_drive = 1'b1;
              s_phase = SP_WACK;
            end
            SP_WACK: begin
              s_drive = 1'b0;
              s_phase = SP_IDLE;
            end
            SP_RDATA: begin
              if (s_bits < 8) begin
                s_tx    = {s_tx[6:0], 1'b0};
                s_drive = ~s_tx[7];
              end else begin
                s_drive = 1'b0;
                s_phase = SP_RACK;
              end
            end
            default: ;
          endcase
        end
      end else begin
        half_cnt++;
      end
    end
    p_scl = c_scl;
    p_sda = c_sda;
  end

  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] w);
    exp_t e;
    @(negedge clk);
    addr  = a;
    rw    = r;
    wdata = w;
    start = 1'b1;
    e.ack = (a != SLV_ADDR);
    e.len = e.ack ? NACK_LEN : FULL_LEN;
    if (!e.ack && r)  exp_rdata = exp_io;
    if (!e.ack && !r) exp_io    = w;
    e.rd = exp_rdata;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned d0);
    int unsigned k = 0;
    while (done_cnt == d0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", done_cnt != d0, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] w);
    int unsigned st0 = n_start;
    int unsigned sp0 = n_stop;
    int unsigned d0  = done_cnt;
    issue(a, r, w);
    wait_done(d0);
    chk("start_cond", n_start - st0, 1);
    chk("stop_cond", n_stop - sp0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned d0;
    reset = 1'b1;
    start = 1'b0;
    addr  = '0;
    rw    = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ack_err", ack_err, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_scl", scl_line, 1'b1);
    chk("rst_sda", sda_line, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // write to present slave
    run_txn(SLV_ADDR, 1'b0, 8'hA5);
    chk("slave_io_wr", s_io, exp_io);

    // read back, master must NACK the data byte
    m_ack = 1'b0;
    run_txn(SLV_ADDR, 1'b1, 8'h00);
    chk("master_nack", m_ack, 1'b1);

    // absent slave
    run_txn(7'h28, 1'b0, 8'h5A);
    chk("slave_io_nack", s_io, exp_io);

    // second start while busy is ignored
    d0 = done_cnt;
    issue(SLV_ADDR, 1'b0, 8'h11);
    repeat (50) @(negedge clk);
    addr  = SLV_ADDR;
    wdata = 8'hEE;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0);
    repeat (400) @(negedge clk);
    chk("ignored_start_dones", done_cnt - d0, 1);
    chk("ignored_start_io", s_io, exp_io);
    chk("ignored_start_sb", sb.size(), 0);

    // reset in the middle of WR bit 3
    issue(SLV_ADDR, 1'b0, 8'h77);
    repeat (214) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    d0 = done_cnt;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_scl", scl_line, 1'b1);
    chk("mid_rst_sda", sda_line, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    sb.delete();
    exp_rdata = 8'h00;
    exp_io    = 8'h11;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_done_after_rst", done_cnt - d0, 0);
    chk("slave_io_aborted", s_io, exp_io);

    run_txn(SLV_ADDR, 1'b0, 8'h3C);
    chk("slave_io_after_rst", s_io, exp_io);
    m_ack = 1'b0;
    run_txn(SLV_ADDR, 1'b1, 8'h00);
    chk("master_nack2", m_ack, 1'b1);

    chk("scl_half_len", half_bad, 0);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
